inst_prefetch_queue: RTL

- Instruction fetch front end between the synchronous instruction memory and the PCPU IF stage.
- Generates i_addr, captures i_datain one cycle later, and buffers up to DEPTH 16-bit instructions with their PCs.
- Hands instructions to the pipeline over a valid/ready handshake.
- Flushes and refetches on branch/jump redirect.

---
 rtl/inst_prefetch_queue.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/inst_prefetch_queue.sv
// -----------------------------------------------------------------------------
// inst_prefetch_queue
//   Instruction fetch front end sitting between a synchronous instruction
//   memory and the pipeline IF stage. Issues one fetch address per cycle,
//   captures the returned word one cycle later, buffers up to DEPTH
//   {instruction, pc} pairs and hands the head entry to the pipeline over a
//   valid/ready handshake. A redirect flushes the queue and refetches from
//   the new target.
//
//   Optional feature macro: FETCH_HALT_STOP_EN
//     defined   - a captured HALT opcode stops issue permanently; queued
//                 entries (HALT included) drain, then the block parks in
//                 HALTED with halted=1 until reset.
//     undefined - HALT is not decoded, halted is tied low.
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   enable       in   global enable; low freezes issue, pop and PC
//   start        in   one-cycle pulse, begins fetching at address 0
//   redirect     in   taken branch/jump this cycle
//   redirect_pc  in   redirect target address [AW]
//   i_addr       out  registered instruction memory address [AW]
//   i_datain     in   memory read data, valid one cycle after i_addr [16]
//   inst         out  head instruction [16]
//   inst_pc      out  head instruction address [AW]
//   inst_valid   out  queue non-empty and not IDLE
//   inst_ready   in   pipeline accepts head this cycle
//   halted       out  HALT drained and fetching stopped
// -----------------------------------------------------------------------------
module inst_prefetch_queue #(
    parameter int unsigned DEPTH   = 4,
`ifdef FETCH_HALT_STOP_EN
    parameter logic [4:0]  HALT_OP = 5'b00001,
`endif
    parameter int unsigned AW      = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  logic          start,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic [AW-1:0] i_addr,
    input  logic [15:0]   i_datain,
    output logic [15:0]   inst,
    output logic [AW-1:0] inst_pc,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic          halted
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN
`ifdef FETCH_HALT_STOP_EN
        , ST_HALTED
`endif
    } state_e;

    state_e          state_q;
    logic [AW-1:0]   fetch_pc_q;
    logic [AW-1:0]   i_addr_q;
    logic [AW-1:0]   req_pc_q;
    logic [CW-1:0]   count_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [PW-1:0]   wr_ptr_q;
    logic            inflight_q;
    logic            drop_q;
    logic [15:0]     data_q [DEPTH];
    logic [AW-1:0]   pc_q   [DEPTH];

    logic            run_c;
    logic            redirect_c;
    logic [CW:0]     pending_c;
    logic            issue_c;
    logic            pop_c;
    logic            capture_c;
    logic            stop_c;
    logic            drop_d;

`ifdef FETCH_HALT_STOP_EN
    logic            stop_q;
    logic            halted_q;
    logic            halt_cap_c;
    logic            halt_pop_c;
`endif

    // Handshake and issue decisions for this cycle
    always_comb begin
        run_c      = (state_q == ST_RUN);
        redirect_c = run_c && enable && redirect;
        pending_c  = {1'b0, count_q} + (CW+1)'(inflight_q);
        pop_c      = enable && inst_valid && inst_ready && !redirect_c;
        capture_c  = inflight_q && !drop_q;
`ifdef FETCH_HALT_STOP_EN
        stop_c     = stop_q;
        // A HALT captured on a redirect edge is flushed, so it must not stop issue
        halt_cap_c = capture_c && !redirect_c && (i_datain[15:11] == HALT_OP);
        // Only the HALT that set stop can be at the head with stop set
        halt_pop_c = pop_c && stop_q && (inst[15:11] == HALT_OP);
`else
        stop_c     = 1'b0;
`endif
        // Count+inflight bound keeps a slot for every outstanding response
        issue_c    = run_c && enable && !redirect_c && !stop_c && (pending_c < DEPTH_W);
        // The response landing on a redirect edge is killed by the queue clear,
        // and no issue happens that edge, so only a HALT can leave a stale request
`ifdef FETCH_HALT_STOP_EN
        drop_d     = issue_c && halt_cap_c;
`else
        drop_d     = 1'b0;
`endif
    end

    // State, fetch PC, request tracking and queue storage
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= '0;
            i_addr_q   <= '0;
            req_pc_q   <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
`ifdef FETCH_HALT_STOP_EN
            stop_q     <= 1'b0;
            halted_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q    <= ST_RUN;
                        fetch_pc_q <= '0;
                    end
                end
                ST_RUN: begin
`ifdef FETCH_HALT_STOP_EN
                    if (halt_pop_c) begin
                        state_q  <= ST_HALTED;
                        halted_q <= 1'b1;
                    end
`endif
                end
                default: begin
                    state_q <= state_q;
                end
            endcase

            inflight_q <= issue_c;
            drop_q     <= drop_d;

            if (issue_c) begin
                i_addr_q   <= fetch_pc_q;
                req_pc_q   <= fetch_pc_q;
                fetch_pc_q <= fetch_pc_q + AW'(1);
            end

            if (redirect_c) begin
                fetch_pc_q <= redirect_pc;
                count_q    <= '0;
                rd_ptr_q   <= '0;
                wr_ptr_q   <= '0;
            end else begin
                if (capture_c) begin
                    data_q[wr_ptr_q] <= i_datain;
                    pc_q[wr_ptr_q]   <= req_pc_q;
                    wr_ptr_q         <= wr_ptr_q + PW'(1);
                end
                if (pop_c) begin
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                end
                unique case ({capture_c, pop_c})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: count_q <= count_q;
                endcase
            end

`ifdef FETCH_HALT_STOP_EN
            // Redirect before the HALT drains cancels the stop
            if (redirect_c) begin
                stop_q <= 1'b0;
            end else if (halt_cap_c) begin
                stop_q <= 1'b1;
            end
`endif
        end
    end

    assign i_addr     = i_addr_q;
    assign inst       = data_q[rd_ptr_q];
    assign inst_pc    = pc_q[rd_ptr_q];
    assign inst_valid = (count_q != '0) && (state_q != ST_IDLE);

`ifdef FETCH_HALT_STOP_EN
    assign halted     = halted_q;
`else
    assign halted     = 1'b0;
`endif

endmodule
